// File: rtl/lbht_update_ctrl.sv
// Write-side sequencer for the local branch history predictor.
// Queues resolved branches, issues one predictor update per free cycle,
// walks the tables for initialisation after reset or a clear request,
// and keeps a saturating count of retired mispredicts.
module lbht_update_ctrl #(
    parameter int unsigned BHRT_IDX   = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [31:0]         res_pc,
    input  logic                res_br_en,
    input  logic                res_pred,
    input  logic                clear_req,
    input  logic                upd_hold,
    output logic                update,
    output logic [31:0]         waddr,
    output logic                br_en,
    output logic                init_we,
    output logic [BHRT_IDX-1:0] init_idx,
    output logic                busy,
    output logic [CNT_W-1:0]    mis_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [BHRT_IDX-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem_pc  [FIFO_DEPTH];
    logic          mem_br  [FIFO_DEPTH];
    logic          mem_mis [FIFO_DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_mis;
    logic          init_done;
    logic          enter_init;

    // Occupancy flags from the registered pointers only, so res_ready never
    // depends combinationally on res_* or upd_hold.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

    // Head-of-queue view driven to the predictor.
    always_comb begin
        waddr    = mem_pc[rd_ptr[AW-1:0]];
        br_en    = mem_br[rd_ptr[AW-1:0]];
        head_mis = mem_mis[rd_ptr[AW-1:0]];
    end

    // Next-state and output decode; every output defaults to its idle value.
    always_comb begin
        state_d   = state_q;
        res_ready = 1'b0;
        update    = 1'b0;
        init_we   = 1'b0;
        busy      = 1'b1;
        init_done = 1'b0;
        case (state_q)
            INIT: begin
                init_we   = 1'b1;
                init_done = (init_idx == IDX_LAST);
                if (init_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b0;
                res_ready = !full;
                update    = !empty && !upd_hold;
                if (clear_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                update = !empty && !upd_hold;
                if (empty) begin
                    state_d = INIT;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Handshake qualifiers; the head retires on the same edge update is high.
    always_comb begin
        push       = res_valid && res_ready;
        pop        = update;
        enter_init = (state_q == DRAIN) && (state_d == INIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Initialisation walk index; wraps from N-1 back to 0 on the exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_idx <= '0;
        end else if (state_q == INIT) begin
            init_idx <= init_idx + BHRT_IDX'(1);
        end
    end

    // Queue pointers, one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Queue storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr[AW-1:0]]  <= res_pc;
            mem_br[wr_ptr[AW-1:0]]  <= res_br_en;
            mem_mis[wr_ptr[AW-1:0]] <= res_br_en ^ res_pred;
        end
    end

    // Saturating mispredict counter, cleared whenever the walk is (re)entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_cnt <= '0;
        end else if (enter_init) begin
            mis_cnt <= '0;
        end else if (pop && head_mis && (mis_cnt != '1)) begin
            mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lbht_update_ctrl.sv
// Scoreboard bench for lbht_update_ctrl with a 16-entry walk and a 4-bit counter.
module tb_lbht_update_ctrl;

    localparam int unsigned TB_IDX = 4;
    localparam int unsigned TB_CNT = 4;
    localparam int          MAXC   = (1 << TB_CNT) - 1;

    logic              clk;
    logic              rst;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_pc;
    logic              res_br_en;
    logic              res_pred;
    logic              clear_req;
    logic              upd_hold;
    logic              update;
    logic [31:0]       waddr;
    logic              br_en;
    logic              init_we;
    logic [TB_IDX-1:0] init_idx;
    logic              busy;
    logic [TB_CNT-1:0] mis_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic        br;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   n_upd   = 0;
    int   exp_mis = 0;

    lbht_update_ctrl #(
        .BHRT_IDX   (TB_IDX),
        .FIFO_DEPTH (4),
        .CNT_W      (TB_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_pc    (res_pc),
        .res_br_en (res_br_en),
        .res_pred  (res_pred),
        .clear_req (clear_req),
        .upd_hold  (upd_hold),
        .update    (update),
        .waddr     (waddr),
        .br_en     (br_en),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .busy      (busy),
        .mis_cnt   (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare each issued update with the oldest accepted push.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (update === 1'b1) begin
                n_upd++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stale_update: update=1 waddr=%h, expected no update (queue empty)", waddr);
                end else begin
                    e = sb.pop_front();
                    if (waddr !== e.pc || br_en !== e.br) begin
                        errors++;
                        $display("FAIL issue_order: waddr=%h br_en=%b, expected waddr=%h br_en=%b",
                                 waddr, br_en, e.pc, e.br);
                    end
                    if (e.mis && exp_mis < MAXC) exp_mis++;
                end
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                e.pc  = res_pc;
                e.br  = res_br_en;
                e.mis = res_br_en ^ res_pred;
                sb.push_back(e);
            end
        end
    end

    always @(negedge rst) begin
        sb.delete();
        exp_mis = 0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [TB_IDX-1:0] e_idx;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (update !== 1'b0)    begin errors++; $display("FAIL rst_update: got %b expected 0", update); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", res_ready); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
        checks++; if (init_idx !== '0)    begin errors++; $display("FAIL rst_idx: got %0d expected 0", init_idx); end
        checks++; if (mis_cnt !== '0)     begin errors++; $display("FAIL rst_mis: got %0d expected 0", mis_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            e_idx = TB_IDX'(c);
            @(negedge clk);
            checks++;
            if (init_we !== 1'b1 || init_idx !== e_idx || busy !== 1'b1) begin
                errors++;
                $display("FAIL walk: init_we=%b init_idx=%0d busy=%b, expected 1 %0d 1", init_we, init_idx, busy, e_idx);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_ready !== 1'b1 || init_we !== 1'b0) begin
            errors++;
            $display("FAIL walk_exit: busy=%b res_ready=%b init_we=%b, expected 0 1 0", busy, res_ready, init_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_run_basic();
        logic [31:0] pcs [3];
        logic        brs [3];
        int          n0;
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        brs[0] = 1'b1;    brs[1] = 1'b0;    brs[2] = 1'b1;
        n0 = n_upd;
        upd_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = pcs[i]; res_br_en = brs[i]; res_pred = 1'b1;
            @(negedge clk);
            checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", res_ready); end
            checks++;
            if (update !== (i != 0)) begin
                errors++;
                $display("FAIL basic_latency: update=%b expected %b in push cycle %0d", update, (i != 0), i);
            end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        repeat (4) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (n_upd - n0 != 3) begin errors++; $display("FAIL basic_count: got %0d updates expected 3", n_upd - n0); end
        checks++; if (mis_cnt !== 4'd1) begin errors++; $display("FAIL basic_mis: got %0d expected 1", mis_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold_full();
        upd_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1; res_pc = 32'h200 + 32'(4 * i);
            res_br_en = 1'($urandom); res_pred = 1'($urandom);
            @(negedge clk);
            checks++;
            if (res_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready: push %0d res_ready=%b expected %b", i, res_ready, (i < 4));
            end
            checks++; if (update !== 1'b0) begin errors++; $display("FAIL hold_update: got %b expected 0", update); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", res_ready); end
        @(posedge clk); #1;
        upd_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (update !== 1'b1 || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: update=%b res_ready=%b, expected 1 0", update, res_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL space_visible: got %b expected 1", res_ready); end
        @(posedge clk); #1;
        res_valid = 1'b0;
        repeat (8) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL hold_drain: %0d entries not issued, expected 0", sb.size()); end
        checks++;
        if (mis_cnt !== TB_CNT'(exp_mis)) begin
            errors++;
            $display("FAIL hold_mis: got %0d expected %0d", mis_cnt, exp_mis);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        upd_hold = 1'b0;
        for (int i = 0; i < (1 << TB_CNT) + 3; i++) begin
            res_valid = 1'b1; res_pc = 32'h300 + 32'(4 * i);
            res_br_en = 1'(i); res_pred = ~res_br_en;
            @(negedge clk);
            checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b expected 1", res_ready); end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        repeat (4) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (mis_cnt !== 4'd15) begin errors++; $display("FAIL mis_saturate: got %0d expected 15", mis_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int                found;
        logic [TB_IDX-1:0] e_idx;
        upd_hold = 1'b1;
        res_valid = 1'b1; res_pc = 32'h400; res_br_en = 1'b1; res_pred = 1'b0;
        @(negedge clk);
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL clr_push0: got %b expected 1", res_ready); end
        @(posedge clk); #1;
        res_pc = 32'h404; res_br_en = 1'b0; res_pred = 1'b0; clear_req = 1'b1;
        @(negedge clk);
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL clr_push1: got %b expected 1", res_ready); end
        @(posedge clk); #1;
        clear_req = 1'b0; res_pc = 32'h408;
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_entry: res_ready=%b busy=%b, expected 0 1", res_ready, busy);
        end
        @(posedge clk); #1;
        res_valid = 1'b0; upd_hold = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (init_we === 1'b1) begin found = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL drain_timeout: init_we=%b expected 1 within 20 cycles", init_we); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_issue: %0d entries not issued, expected 0", sb.size()); end
        checks++; if (mis_cnt !== '0) begin errors++; $display("FAIL init_mis_clear: got %0d expected 0", mis_cnt); end
        checks++; if (init_idx !== '0) begin errors++; $display("FAIL init_idx0: got %0d expected 0", init_idx); end
        exp_mis = 0;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk); #1;
            clear_req = (c == 5);
            e_idx = TB_IDX'(c);
            @(negedge clk);
            checks++;
            if (init_we !== 1'b1 || init_idx !== e_idx) begin
                errors++;
                $display("FAIL rewalk: init_we=%b init_idx=%0d, expected 1 %0d", init_we, init_idx, e_idx);
            end
        end
        @(posedge clk); #1;
        clear_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_ready !== 1'b1) begin
            errors++;
            $display("FAIL rewalk_exit: busy=%b res_ready=%b, expected 0 1", busy, res_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n0;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (init_idx !== 4'd7) begin errors++; $display("FAIL mid_idx7: got %0d expected 7", init_idx); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (init_idx !== '0 || busy !== 1'b1 || update !== 1'b0 || res_ready !== 1'b0 || mis_cnt !== '0) begin
            errors++;
            $display("FAIL async_rst_init: idx=%0d busy=%b update=%b ready=%b mis=%0d, expected 0 1 0 0 0",
                     init_idx, busy, update, res_ready, mis_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (init_idx !== '0 || init_we !== 1'b1) begin
            errors++;
            $display("FAIL walk_restart: idx=%0d init_we=%b, expected 0 1", init_idx, init_we);
        end
        repeat (16) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_run: busy=%b expected 0", busy); end
        @(posedge clk); #1;
        upd_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            res_valid = 1'b1; res_pc = 32'h500 + 32'(4 * i); res_br_en = 1'b1; res_pred = 1'b0;
            @(negedge clk);
            checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL mid_push: got %b expected 1", res_ready); end
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (update !== 1'b0 || res_ready !== 1'b0 || busy !== 1'b1 || init_idx !== '0 || mis_cnt !== '0) begin
            errors++;
            $display("FAIL async_rst_run: update=%b ready=%b busy=%b idx=%0d mis=%0d, expected 0 0 1 0 0",
                     update, res_ready, busy, init_idx, mis_cnt);
        end
        upd_hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n0 = n_upd;
        repeat (22) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (n_upd != n0) begin errors++; $display("FAIL no_stale: got %0d updates expected 0", n_upd - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_run: busy=%b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b0;
        res_valid = 1'b0;
        res_pc    = '0;
        res_br_en = 1'b0;
        res_pred  = 1'b0;
        clear_req = 1'b0;
        upd_hold  = 1'b0;
        test_reset();
        test_run_basic();
        test_hold_full();
        test_saturation();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
